// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path (and the future receiver).
// Latency: none, declarations only.
// Backpressure: n/a. Optional build macro UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;
`endif

  // Width needed to count 0..clks_per_bit-1; illegal sizes are rejected by the users.
  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, tick on the terminal count.
// Latency: tick is combinational from the registered count, high for one cycle per bit.
// Backpressure: none; restart zeroes the count so a new frame starts a full bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running bit counter, wraps at the terminal count and holds at zero when idle.
  always_ff @(posedge clk) begin
    if (clr || restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERMINAL) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == TERMINAL);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frames each accepted word as start, data (LSB first), [parity], stop.
// Latency: start bit appears on tx the cycle after the handshake; frame = bits*CLKS_PER_BIT.
// Backpressure: ready is low for the whole frame; macro UART_TX_PARITY_EN adds a parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  // One index register serves both the data bit position and the stop bit position.
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [IDX_W-1:0]      bit_idx;
  logic                  tick;
  logic                  handshake;

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the word at latch time, since the shift register is consumed.
  logic par_bit;
`else
  localparam bit unused_parity_odd = PARITY_ODD;
`endif

  // Ready is forced low during reset and otherwise tracks the idle state.
  assign ready      = (state == IDLE) && !clr;
  assign handshake  = valid && ready;
  assign shreg_next = shreg >> 1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .clr    (clr),
    .en     (state != IDLE),
    .restart(handshake),
    .tick   (tick)
  );

  // Frame sequencer: tx and busy are registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            shreg   <= data;
`ifdef UART_TX_PARITY_EN
            par_bit <= (^data) ^ PARITY_ODD;
`endif
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
            bit_idx <= '0;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= par_bit;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              shreg   <= shreg_next;
              tx      <= shreg_next[0];
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state   <= STOP;
            tx      <= 1'b1;
            bit_idx <= '0;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              state   <= IDLE;
              busy    <= 1'b0;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
